// File: rtl/jtlabrun_pal_pkg.sv
// Shared Labyrinth Runner video constants: colour field offsets, palette
// pipeline depth, video fetch FSM states and the colour-word decoder.
package jtlabrun_pal_pkg;

    localparam int RLSB       = 0;
    localparam int GLSB       = 5;
    localparam int BLSB       = 10;
    localparam int CW         = 5;
    localparam int PIPE_DEPTH = 2;

    typedef enum logic {
        ST_HI = 1'b0,
        ST_LO = 1'b1
    } pal_state_e;

    typedef struct packed {
        logic [CW-1:0] b;
        logic [CW-1:0] g;
        logic [CW-1:0] r;
    } rgb_t;

    // Bit 15 of the colour word carries nothing, so only 15 bits come in.
    function automatic rgb_t pal_decode(input logic [14:0] col);
        rgb_t c;
        c.r = col[RLSB +: CW];
        c.g = col[GLSB +: CW];
        c.b = col[BLSB +: CW];
        return c;
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM, single clock, synchronous read on both ports with
// read-before-write behaviour. Only the output registers are reset.
module jtframe_dual_ram #(
    parameter int DW      = 8,
    parameter int AW      = 8,
    parameter     SIMFILE = ""
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] data0,
    input  logic [AW-1:0] addr0,
    input  logic          we0,
    output logic [DW-1:0] q0,
    input  logic [DW-1:0] data1,
    input  logic [AW-1:0] addr1,
    input  logic          we1,
    output logic [DW-1:0] q1
);

    logic [DW-1:0] mem_r [0:(2**AW)-1];
    logic [DW-1:0] q0_r;
    logic [DW-1:0] q1_r;

    // Preloading from SIMFILE is handled by the simulation environment.
    if (SIMFILE != "") begin : g_simfile
    end

    // Array writes; port 0 wins if both ports write in the same cycle.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem_r[addr0] <= data0;
        end else if (we1) begin
            mem_r[addr1] <= data1;
        end
    end

    // Registered reads see the array contents from before this cycle's write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q0_r <= {DW{1'b0}};
            q1_r <= {DW{1'b0}};
        end else begin
            q0_r <= mem_r[addr0];
            q1_r <= mem_r[addr1];
        end
    end

    assign q0 = q0_r;
    assign q1 = q1_r;

endmodule

// File: rtl/jtlabrun_pal.sv
// Labyrinth Runner palette stage: CPU-visible 256-byte palette RAM, two-phase
// video fetch of 16-bit colour words, blanking delay and 5-bit RGB output.
import jtlabrun_pal_pkg::*;

module jtlabrun_pal #(
    parameter SIMFILE = ""
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pxl2_cen,
    input  logic       pxl_cen,
    input  logic       cpu_cen,
    input  logic       pal_cs,
    input  logic       cpu_rnw,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    output logic [7:0] pal_dout,
    input  logic [6:0] gfx_pxl,
    input  logic       preLHBL,
    input  logic       preLVBL,
    output logic       LHBL,
    output logic       LVBL,
    output logic [4:0] red,
    output logic [4:0] green,
    output logic [4:0] blue
);

    pal_state_e            state_r;
    logic [6:0]            idx_r;
    logic [6:0]            hi_r;
    logic [PIPE_DEPTH-1:0] hbl_r;
    logic [PIPE_DEPTH-1:0] vbl_r;
    rgb_t                  rgb_r;
    logic [7:0]            vaddr_s;
    logic [7:0]            vq_s;
    logic                  cpu_we_s;

    assign cpu_we_s = cpu_cen & pal_cs & ~cpu_rnw;

    jtframe_dual_ram #(
        .DW      (8),
        .AW      (8),
        .SIMFILE (SIMFILE)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .data0 (cpu_dout),
        .addr0 (cpu_addr),
        .we0   (cpu_we_s),
        .q0    (pal_dout),
        .data1 (8'h00),
        .addr1 (vaddr_s),
        .we1   (1'b0),
        .q1    (vq_s)
    );

    // Video read address: high byte while in HI, low byte while in LO.
    always_comb begin
        vaddr_s = {idx_r, 1'b0};
        case (state_r)
            ST_HI:   vaddr_s = {idx_r, 1'b0};
            ST_LO:   vaddr_s = {idx_r, 1'b1};
            default: vaddr_s = {idx_r, 1'b0};
        endcase
    end

    // Fetch FSM, blanking delay and RGB output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_HI;
            idx_r   <= 7'd0;
            hi_r    <= 7'd0;
            hbl_r   <= {PIPE_DEPTH{1'b0}};
            vbl_r   <= {PIPE_DEPTH{1'b0}};
            rgb_r   <= '0;
        end else if (pxl2_cen) begin
            if (pxl_cen) begin
                state_r <= ST_HI;
                idx_r   <= gfx_pxl;
                hbl_r   <= {hbl_r[PIPE_DEPTH-2:0], preLHBL};
                vbl_r   <= {vbl_r[PIPE_DEPTH-2:0], preLVBL};
                // Gate with the stage that becomes LHBL/LVBL on this same edge.
                if (hbl_r[0] & vbl_r[0]) begin
                    rgb_r <= pal_decode({hi_r, vq_s});
                end else begin
                    rgb_r <= '0;
                end
            end else begin
                case (state_r)
                    ST_HI: begin
                        state_r <= ST_LO;
                        hi_r    <= vq_s[6:0];
                    end
                    ST_LO:   state_r <= ST_LO;
                    default: state_r <= ST_HI;
                endcase
            end
        end
    end

    assign LHBL  = hbl_r[PIPE_DEPTH-1];
    assign LVBL  = vbl_r[PIPE_DEPTH-1];
    assign red   = rgb_r.r;
    assign green = rgb_r.g;
    assign blue  = rgb_r.b;

endmodule

// File: tb/tb_jtlabrun_pal.sv
// Directed bench for jtlabrun_pal: table of pixel vectors plus hand-written
// sequences for CPU reads, write/read collision and mid-line reset.
module tb_jtlabrun_pal;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pxl2_cen;
    logic       pxl_cen;
    logic       cpu_cen;
    logic       pal_cs;
    logic       cpu_rnw;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_dout;
    logic [7:0] pal_dout;
    logic [6:0] gfx_pxl;
    logic       preLHBL;
    logic       preLVBL;
    logic       LHBL;
    logic       LVBL;
    logic [4:0] red;
    logic [4:0] green;
    logic [4:0] blue;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] cnt     = 3'd0;

    typedef struct {
        logic [6:0] idx;
        logic       h;
        logic       v;
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
        logic       lh;
        logic       lv;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    jtlabrun_pal #(.SIMFILE("")) dut (
        .clk      (clk),
        .rstn     (rstn),
        .pxl2_cen (pxl2_cen),
        .pxl_cen  (pxl_cen),
        .cpu_cen  (cpu_cen),
        .pal_cs   (pal_cs),
        .cpu_rnw  (cpu_rnw),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .pal_dout (pal_dout),
        .gfx_pxl  (gfx_pxl),
        .preLHBL  (preLHBL),
        .preLVBL  (preLVBL),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .red      (red),
        .green    (green),
        .blue     (blue)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [6:0] idx, input logic h, input logic v,
                                input logic [4:0] r, input logic [4:0] g,
                                input logic [4:0] b, input logic lh, input logic lv);
        vec_t t;
        t.idx = idx; t.h = h; t.v = v;
        t.r = r; t.g = g; t.b = b; t.lh = lh; t.lv = lv;
        return t;
    endfunction

    // One clk cycle; enables follow a /4 (pxl2) and /8 (pxl) pattern.
    task automatic tick();
        pxl2_cen = (cnt[1:0] == 2'd3);
        pxl_cen  = (cnt == 3'd7);
        @(posedge clk);
        #1;
        cnt      = cnt + 3'd1;
        pxl2_cen = 1'b0;
        pxl_cen  = 1'b0;
    endtask

    task automatic pxl_edge();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            done = (cnt == 3'd7);
            tick();
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        cpu_cen = 1'b1; pal_cs = 1'b1; cpu_rnw = 1'b0;
        cpu_addr = a; cpu_dout = d;
        tick();
        cpu_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1;
    endtask

    task automatic check_pix(input string name, input vec_t e);
        check(name, {15'd0, red, green, blue, LHBL, LVBL},
              {15'd0, e.r, e.g, e.b, e.lh, e.lv});
    endtask

    initial begin
        rstn = 1'b0; pxl2_cen = 1'b0; pxl_cen = 1'b0;
        cpu_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1;
        cpu_addr = 8'd0; cpu_dout = 8'd0;
        gfx_pxl = 7'd0; preLHBL = 1'b0; preLVBL = 1'b0;

        vecs[0]  = mk(7'd5,   1'b1, 1'b1, 5'd0,  5'd0,  5'd31, 1'b1, 1'b1);
        vecs[1]  = mk(7'd127, 1'b1, 1'b1, 5'd0,  5'd31, 5'd0,  1'b1, 1'b1);
        vecs[2]  = mk(7'd2,   1'b1, 1'b1, 5'd1,  5'd1,  5'd1,  1'b1, 1'b1);
        vecs[3]  = mk(7'd3,   1'b1, 1'b1, 5'd20, 5'd17, 5'd4,  1'b1, 1'b1);
        vecs[4]  = mk(7'd1,   1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0);
        vecs[5]  = mk(7'd1,   1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0);
        vecs[6]  = mk(7'd1,   1'b1, 1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1);
        vecs[7]  = mk(7'd1,   1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1);
        vecs[8]  = mk(7'd1,   1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1);
        vecs[9]  = mk(7'd1,   1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1);
        vecs[10] = mk(7'd1,   1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1);
        vecs[11] = mk(7'd1,   1'b1, 1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1);
        vecs[12] = mk(7'd3,   1'b1, 1'b1, 5'd20, 5'd17, 5'd4,  1'b1, 1'b1);
        vecs[13] = mk(7'd0,   1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1);
        vecs[14] = mk(7'd127, 1'b1, 1'b1, 5'd0,  5'd31, 5'd0,  1'b1, 1'b1);

        // Reset state
        tick(); tick(); tick();
        check("reset_rgb",   {17'd0, red, green, blue}, 32'd0);
        check("reset_blank", {30'd0, LHBL, LVBL}, 32'd0);
        check("reset_dout",  {24'd0, pal_dout}, 32'd0);
        rstn = 1'b1;

        // Palette contents
        cpu_write(8'd0,   8'h00); cpu_write(8'd1,   8'h00);
        cpu_write(8'd2,   8'h7F); cpu_write(8'd3,   8'hFF);
        cpu_write(8'd4,   8'h84); cpu_write(8'd5,   8'h21);
        cpu_write(8'd6,   8'h12); cpu_write(8'd7,   8'h34);
        cpu_write(8'd10,  8'h7C); cpu_write(8'd11,  8'h00);
        cpu_write(8'd255, 8'hE0); cpu_write(8'd254, 8'h03);

        // CPU reads: one clk latency, reads never write
        cpu_addr = 8'd10; tick();
        check("cpu_rd_10", {24'd0, pal_dout}, 32'h7C);
        cpu_addr = 8'd255; tick();
        check("cpu_rd_255", {24'd0, pal_dout}, 32'hE0);
        cpu_cen = 1'b1; pal_cs = 1'b1; cpu_rnw = 1'b1;
        cpu_addr = 8'd4; cpu_dout = 8'h55; tick(); tick();
        cpu_cen = 1'b0; pal_cs = 1'b0;
        check("cpu_rd_no_write", {24'd0, pal_dout}, 32'h84);

        // Table: vector i shows up after its second pxl_cen
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                gfx_pxl = vecs[i].idx; preLHBL = vecs[i].h; preLVBL = vecs[i].v;
            end else begin
                gfx_pxl = 7'd0; preLHBL = 1'b0; preLVBL = 1'b0;
            end
            pxl_edge();
            if (i > 0) check_pix($sformatf("vec%0d", i - 1), vecs[i-1]);
        end

        // Collision: byte 11 written on the clk the low byte of entry 5 is read
        gfx_pxl = 7'd5; preLHBL = 1'b1; preLVBL = 1'b1;
        pxl_edge();
        for (int i = 0; i < 6; i++) tick();
        cpu_write(8'd11, 8'h1F);
        tick();
        check("collide_old", {17'd0, red, green, blue}, {17'd0, 5'd0, 5'd0, 5'd31});
        pxl_edge();
        check("collide_new", {17'd0, red, green, blue}, {17'd0, 5'd31, 5'd0, 5'd31});

        // Mid-line reset with white on screen
        gfx_pxl = 7'd1;
        pxl_edge(); pxl_edge(); pxl_edge();
        check("white_before", {17'd0, red, green, blue}, {17'd0, 15'h7FFF});
        tick(); tick();
        rstn = 1'b0;
        #1;
        check("async_rst_rgb",   {17'd0, red, green, blue}, 32'd0);
        check("async_rst_blank", {30'd0, LHBL, LVBL}, 32'd0);
        check("async_rst_dout",  {24'd0, pal_dout}, 32'd0);
        tick(); tick(); tick();
        rstn = 1'b1;
        pxl_edge();
        check("rel_first", {15'd0, red, green, blue, LHBL, LVBL}, 32'd0);
        pxl_edge();
        check("rel_second", {15'd0, red, green, blue, LHBL, LVBL}, {15'd0, 15'h7FFF, 2'b11});
        cpu_addr = 8'd2; tick();
        check("retained", {24'd0, pal_dout}, 32'h7F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
